xillybus_ap_fifo_bridge: RTL and testbench
==========================================

# xillybus_ap_fifo_bridge

Bridges the 128-bit Xillybus user streams to Vivado HLS `ap_fifo` ports, sitting directly downstream and upstream of the `xillybus` top wrapper on `bus_clk`. Host-to-FPGA words from `user_w_write_128_*` are buffered and presented as a first-word-fall-through (FWFT) `ap_fifo` source. FPGA-to-host words from an `ap_fifo` sink are buffered and presented as a Xillybus read FIFO with end-of-file signalling. Both buffers are flushed according to the Xillybus open/close rules.

## Interface
- `DATA_W`, 128: word width on both paths.
- `DEPTH_LOG2`, 9: log2 of the depth of each buffer (512 words).

Ports:
- `bus_clk` in 1: sole clock.
- `user_reset` in 1: synchronous, active-high reset.
- `user_w_write_128_wren` in 1: host word strobe.
- `user_w_write_128_data` in DATA_W: host word.
- `user_w_write_128_full` out 1: host-to-FPGA (h2c) buffer full.
- `user_w_write_128_open` in 1: host write file open.
- `h2c_dout` out DATA_W: FWFT head word.
- `h2c_empty_n` out 1: head word is valid.
- `h2c_read` in 1: pops the head word.
- `h2c_overflow` out 1: sticky flag; a write was dropped.
- `c2h_din` in DATA_W: kernel word.
- `c2h_full_n` out 1: FPGA-to-host (c2h) buffer can accept a word.
- `c2h_write` in 1: kernel push strobe.
- `c2h_done` in 1: one-cycle pulse marking the end of the kernel output stream.
- `user_r_read_128_rden` in 1: host pop strobe.
- `user_r_read_128_data` out DATA_W: popped word, registered.
- `user_r_read_128_empty` out 1: c2h buffer empty.
- `user_r_read_128_eof` out 1: end of stream.
- `user_r_read_128_open` in 1: host read file open.

## Operation
**Buffers**
- Each direction is a circular buffer with read pointer, write pointer and occupancy counter.
- Pointers are DEPTH_LOG2 bits wide and wrap modulo 2^DEPTH_LOG2.
- The occupancy counter is DEPTH_LOG2+1 bits wide.
- Full means count == 2^DEPTH_LOG2. Empty means count == 0.

**h2c path**
- A push is accepted when `wren` is high and the buffer is not full.
- `wren` while full drops the word and sets `h2c_overflow`. The flag clears only on reset.
- A pop is accepted when `h2c_read` is high and `h2c_empty_n` is high. `h2c_read` while empty is ignored.
- Simultaneous push and pop: both are accepted and the count is unchanged.
- A push on a full cycle is dropped even if a pop occurs in the same cycle.
- While `user_w_write_128_open` is 0, the buffer is held flushed: pointers and count are 0, and pushes are ignored.

**c2h path**
- A push is accepted when `c2h_write` is high and `c2h_full_n` is high.
- A pop is accepted when `rden` is high and the buffer is not empty. `rden` while empty is ignored.
- `c2h_done` sets `done_flag`.
- `user_r_read_128_eof` = `done_flag` AND empty, so it asserts only together with `user_r_read_128_empty`.
- Close flush: `open_d` is a registered copy of `user_r_read_128_open`. On the cycle where `open_d` is 1 and `open` is 0 (file close), the buffer is flushed and `done_flag` is cleared.
- Data pushed before the host opens the file is retained.
- `c2h_done` arriving in the same cycle as the close flush: the flush wins and `done_flag` ends up 0.

**Reset**
- All pointers, counts, `done_flag`, `open_d`, `h2c_overflow` and `user_r_read_128_data` are cleared to 0.
- Output values during and after reset: `user_w_write_128_full`=0, `h2c_empty_n`=0, `h2c_dout`=don't-care (the bench must not check it), `user_r_read_128_empty`=1, `user_r_read_128_eof`=0.
- `c2h_full_n` is forced to 0 while `user_reset` is high and is 1 afterwards.
- Reset in the middle of a transfer discards all buffered words.

## Timing
- Flags (full, empty, `empty_n`, `full_n`, `eof`) are decoded combinationally from registered counts. They therefore change the cycle after the push or pop that caused them.
- h2c: `wren` in cycle N into an empty buffer gives `h2c_empty_n`=1 and a valid `h2c_dout` in cycle N+1.
- h2c: `h2c_read` in cycle M advances `h2c_dout` to the next word in cycle M+1.
- c2h: `c2h_write` in cycle N gives `user_r_read_128_empty`=0 in cycle N+1.
- c2h: an accepted `rden` in cycle M gives a valid `user_r_read_128_data` in cycle M+1. This is the standard Xillybus FIFO read latency.
- `user_r_read_128_data` holds its value when no pop occurs.
- `eof` rises the cycle after the later of two events: the `done_flag` set, or the last pop.
- Sustained throughput is one word per cycle in each direction.

## Structure
- Shared package `xillybus_bridge_pkg` holds `DATA_W_DEF=128`, `DEPTH_LOG2_DEF=9` and the word typedef `word128_t`.
- Sub-module `xillybus_sync_fifo` (parameters DATA_W and DEPTH_LOG2; ports: push, pop, flush, full, empty, count, head, registered read data) is instantiated twice.
- The top level contains only `done_flag`, `open_d`, `h2c_overflow` and the glue logic.

## Test plan
- Reset, then idle: `user_w_write_128_full`=0, `h2c_empty_n`=0, `user_r_read_128_empty`=1, `eof`=0, `c2h_full_n`=1 after reset deasserts.
- With open=1, write 512 words 0..511: `full` rises the cycle after word 511. A 513th `wren` sets `h2c_overflow`. Drain via `h2c_read` and check the exact order 0..511 with no duplication.
- Assert `h2c_read` and `wren` in the same cycle at count 5: count stays 5. Assert push and pop together at full: the push is dropped.
- Push 3 words on c2h, pulse `c2h_done`, then pop 3 times: data appears 1 cycle after each `rden`, and `eof` rises together with `empty` after the third pop.
- Drop `user_r_read_128_open` with 10 words buffered and `done_flag` set: next cycle `empty`=1 and `eof`=0. Drop `user_w_write_128_open`: `h2c_empty_n`=0 and writes are ignored.
- Assert reset with both buffers half full: all flags return to their reset values the next cycle.

Source files
------------

// File: rtl/xillybus_bridge_pkg.sv
// Shared widths and word type for the Xillybus <-> ap_fifo bridge.
`timescale 1ns/1ps
package xillybus_bridge_pkg;

  localparam int DATA_W_DEF     = 128;
  localparam int DEPTH_LOG2_DEF = 9;

  typedef logic [DATA_W_DEF-1:0] word128_t;

endpackage

// File: rtl/xillybus_sync_fifo.sv
// Circular-buffer FIFO with FWFT head word and a registered pop data port.
`timescale 1ns/1ps
module xillybus_sync_fifo #(
  parameter int DATA_W     = 128,
  parameter int DEPTH_LOG2 = 9
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  logic                  i_flush,
  input  logic [DATA_W-1:0]     i_din,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [DEPTH_LOG2:0]   o_count,
  output logic [DATA_W-1:0]     o_head,
  output logic [DATA_W-1:0]     o_rdData
);

  logic [DATA_W-1:0]     r_mem [0:(1<<DEPTH_LOG2)-1];
  logic [DEPTH_LOG2-1:0] r_rdPtr;
  logic [DEPTH_LOG2-1:0] r_wrPtr;
  logic [DEPTH_LOG2:0]   r_count;
  logic [DATA_W-1:0]     r_rdData;
  logic                  w_pushOk;
  logic                  w_popOk;

  // Count never exceeds 2^DEPTH_LOG2, so its MSB alone means full.
  assign o_full   = r_count[DEPTH_LOG2];
  assign o_empty  = (r_count == '0);
  assign o_count  = r_count;
  assign o_head   = r_mem[r_rdPtr];
  assign o_rdData = r_rdData;

  assign w_pushOk = i_push && !o_full && !i_flush;
  assign w_popOk  = i_pop && !o_empty && !i_flush;

  always_ff @(posedge i_clk) begin
    if (w_pushOk) begin
      r_mem[r_wrPtr] <= i_din;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rdPtr  <= '0;
      r_wrPtr  <= '0;
      r_count  <= '0;
      r_rdData <= '0;
    end else if (i_flush) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_pushOk) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_popOk) begin
        r_rdPtr  <= r_rdPtr + 1'b1;
        r_rdData <= r_mem[r_rdPtr];
      end
      if (w_pushOk && !w_popOk) begin
        r_count <= r_count + 1'b1;
      end else if (w_popOk && !w_pushOk) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/xillybus_ap_fifo_bridge.sv
// Bridges Xillybus 128-bit user streams to HLS ap_fifo ports, one buffer per
// direction, with Xillybus open/close flushing and end-of-file signalling.
`timescale 1ns/1ps
module xillybus_ap_fifo_bridge
  import xillybus_bridge_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic              bus_clk,
  input  logic              user_reset,
  input  logic              user_w_write_128_wren,
  input  logic [DATA_W-1:0] user_w_write_128_data,
  output logic              user_w_write_128_full,
  input  logic              user_w_write_128_open,
  output logic [DATA_W-1:0] h2c_dout,
  output logic              h2c_empty_n,
  input  logic              h2c_read,
  output logic              h2c_overflow,
  input  logic [DATA_W-1:0] c2h_din,
  output logic              c2h_full_n,
  input  logic              c2h_write,
  input  logic              c2h_done,
  input  logic              user_r_read_128_rden,
  output logic [DATA_W-1:0] user_r_read_128_data,
  output logic              user_r_read_128_empty,
  output logic              user_r_read_128_eof,
  input  logic              user_r_read_128_open
);

  logic                r_doneFlag;
  logic                r_openD;
  logic                r_h2cOverflow;
  logic                w_h2cFull;
  logic                w_h2cEmpty;
  logic                w_h2cPush;
  logic                w_h2cFlush;
  logic [DEPTH_LOG2:0] w_h2cCount;
  logic [DATA_W-1:0]   w_h2cRdData;
  logic                w_c2hFull;
  logic                w_c2hEmpty;
  logic                w_c2hPush;
  logic                w_closeFlush;
  logic [DEPTH_LOG2:0] w_c2hCount;
  logic [DATA_W-1:0]   w_c2hHead;
  logic                w_unusedBits;

  // The h2c buffer is held empty for as long as the host write file is closed.
  assign w_h2cPush  = user_w_write_128_wren && user_w_write_128_open;
  assign w_h2cFlush = !user_w_write_128_open;

  xillybus_sync_fifo #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_h2cFifo (
    .i_clk    (bus_clk),
    .i_reset  (user_reset),
    .i_push   (w_h2cPush),
    .i_pop    (h2c_read),
    .i_flush  (w_h2cFlush),
    .i_din    (user_w_write_128_data),
    .o_full   (w_h2cFull),
    .o_empty  (w_h2cEmpty),
    .o_count  (w_h2cCount),
    .o_head   (h2c_dout),
    .o_rdData (w_h2cRdData)
  );

  assign user_w_write_128_full = w_h2cFull;
  assign h2c_empty_n           = !w_h2cEmpty;
  assign h2c_overflow          = r_h2cOverflow;

  always_ff @(posedge bus_clk) begin
    if (user_reset) begin
      r_h2cOverflow <= 1'b0;
    end else if (w_h2cPush && w_h2cFull) begin
      r_h2cOverflow <= 1'b1;
    end
  end

  // Closing the read file (falling edge of open) discards c2h data and EOF.
  assign w_closeFlush = r_openD && !user_r_read_128_open;
  assign c2h_full_n   = !user_reset && !w_c2hFull;
  assign w_c2hPush    = c2h_write && c2h_full_n;

  xillybus_sync_fifo #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_c2hFifo (
    .i_clk    (bus_clk),
    .i_reset  (user_reset),
    .i_push   (w_c2hPush),
    .i_pop    (user_r_read_128_rden),
    .i_flush  (w_closeFlush),
    .i_din    (c2h_din),
    .o_full   (w_c2hFull),
    .o_empty  (w_c2hEmpty),
    .o_count  (w_c2hCount),
    .o_head   (w_c2hHead),
    .o_rdData (user_r_read_128_data)
  );

  assign user_r_read_128_empty = w_c2hEmpty;
  assign user_r_read_128_eof   = r_doneFlag && w_c2hEmpty;

  always_ff @(posedge bus_clk) begin
    if (user_reset) begin
      r_openD    <= 1'b0;
      r_doneFlag <= 1'b0;
    end else begin
      r_openD <= user_r_read_128_open;
      if (w_closeFlush) begin
        r_doneFlag <= 1'b0;
      end else if (c2h_done) begin
        r_doneFlag <= 1'b1;
      end
    end
  end

  assign w_unusedBits = ^{w_h2cCount, w_c2hCount, w_h2cRdData, w_c2hHead};

endmodule

// File: tb/tb_xillybus_ap_fifo_bridge.sv
// Self-checking bench: queue-based reference model of both bridge directions.
`timescale 1ns/1ps
module tb_xillybus_ap_fifo_bridge;

  localparam int DW    = 128;
  localparam int DEPTH = 512;

  logic          clk = 1'b0;
  logic          reset;
  logic          wren;
  logic [DW-1:0] wdata;
  logic          wFull;
  logic          wOpen;
  logic [DW-1:0] h2cDout;
  logic          h2cEmptyN;
  logic          h2cRead;
  logic          h2cOvf;
  logic [DW-1:0] c2hDin;
  logic          c2hFullN;
  logic          c2hWrite;
  logic          c2hDone;
  logic          rden;
  logic [DW-1:0] rData;
  logic          rEmpty;
  logic          rEof;
  logic          rOpen;

  logic [DW-1:0] h2cQ[$];
  logic [DW-1:0] c2hQ[$];
  bit            mDone;
  bit            mOvf;
  bit            mOpenD;
  logic [DW-1:0] mRd;

  int nChecks = 0;
  int nPass   = 0;

  always #5 clk = ~clk;

  xillybus_ap_fifo_bridge dut (
    .bus_clk               (clk),
    .user_reset            (reset),
    .user_w_write_128_wren (wren),
    .user_w_write_128_data (wdata),
    .user_w_write_128_full (wFull),
    .user_w_write_128_open (wOpen),
    .h2c_dout              (h2cDout),
    .h2c_empty_n           (h2cEmptyN),
    .h2c_read              (h2cRead),
    .h2c_overflow          (h2cOvf),
    .c2h_din               (c2hDin),
    .c2h_full_n            (c2hFullN),
    .c2h_write             (c2hWrite),
    .c2h_done              (c2hDone),
    .user_r_read_128_rden  (rden),
    .user_r_read_128_data  (rData),
    .user_r_read_128_empty (rEmpty),
    .user_r_read_128_eof   (rEof),
    .user_r_read_128_open  (rOpen)
  );

  function automatic logic [DW-1:0] rndWord();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [DW-1:0] modelHead();
    return (h2cQ.size() > 0) ? h2cQ[0] : '0;
  endfunction

  // Advance the reference model by one clock using the inputs currently driven.
  task automatic modelStep();
    bit h2cWasFull;
    if (reset) begin
      h2cQ.delete();
      c2hQ.delete();
      mDone  = 0;
      mOvf   = 0;
      mOpenD = 0;
      mRd    = '0;
      return;
    end
    h2cWasFull = (h2cQ.size() == DEPTH);
    if (!wOpen) begin
      h2cQ.delete();
    end else begin
      if (wren && h2cWasFull) mOvf = 1;
      if (h2cRead && h2cQ.size() > 0) void'(h2cQ.pop_front());
      if (wren && !h2cWasFull) h2cQ.push_back(wdata);
    end
    if (mOpenD && !rOpen) begin
      c2hQ.delete();
      mDone = 0;
    end else begin
      if (c2hWrite && c2hQ.size() < DEPTH) begin
        if (rden && c2hQ.size() > 0) mRd = c2hQ.pop_front();
        c2hQ.push_back(c2hDin);
      end else if (rden && c2hQ.size() > 0) begin
        mRd = c2hQ.pop_front();
      end
      if (c2hDone) mDone = 1;
    end
    mOpenD = rOpen;
  endtask

  task automatic tick();
    modelStep();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    wren = 0; h2cRead = 0; c2hWrite = 0; c2hDone = 0; rden = 0;
  endtask

  task automatic test_reset();
    reset = 1; wOpen = 1; rOpen = 1; wdata = '0; c2hDin = '0;
    idleInputs();
    tick();
    tick();
    nChecks++; if (c2hFullN !== 1'b0) $display("[TB] FAIL reset_full_n_low got=%b exp=0", c2hFullN); else nPass++;
    nChecks++; if (wFull !== 1'b0) $display("[TB] FAIL reset_w_full got=%b exp=0", wFull); else nPass++;
    nChecks++; if (h2cEmptyN !== 1'b0) $display("[TB] FAIL reset_empty_n got=%b exp=0", h2cEmptyN); else nPass++;
    nChecks++; if (rEmpty !== 1'b1) $display("[TB] FAIL reset_r_empty got=%b exp=1", rEmpty); else nPass++;
    nChecks++; if (rEof !== 1'b0) $display("[TB] FAIL reset_eof got=%b exp=0", rEof); else nPass++;
    reset = 0;
    tick();
    tick();
    nChecks++; if (c2hFullN !== 1'b1) $display("[TB] FAIL idle_full_n got=%b exp=1", c2hFullN); else nPass++;
    nChecks++; if (h2cOvf !== 1'b0) $display("[TB] FAIL idle_overflow got=%b exp=0", h2cOvf); else nPass++;
    nChecks++; if (rData !== '0) $display("[TB] FAIL idle_rdata got=%h exp=0", rData); else nPass++;
  endtask

  task automatic test_h2c_fill_drain();
    for (int i = 0; i < DEPTH; i++) begin
      wren = 1; wdata = DW'(i);
      tick();
      if (i == DEPTH - 2) begin
        nChecks++; if (wFull !== 1'b0) $display("[TB] FAIL full_early got=%b exp=0", wFull); else nPass++;
      end
    end
    nChecks++; if (wFull !== 1'b1) $display("[TB] FAIL full_after_511 got=%b exp=1", wFull); else nPass++;
    nChecks++; if (h2cOvf !== 1'b0) $display("[TB] FAIL ovf_before_drop got=%b exp=0", h2cOvf); else nPass++;
    wdata = DW'(999);
    tick();
    nChecks++; if (h2cOvf !== 1'b1) $display("[TB] FAIL ovf_after_drop got=%b exp=1", h2cOvf); else nPass++;
    wren = 0; h2cRead = 1;
    for (int i = 0; i < DEPTH; i++) begin
      nChecks++;
      if (h2cEmptyN !== 1'b1 || h2cDout !== DW'(i))
        $display("[TB] FAIL drain_order idx=%0d got=%h/%b exp=%h/1", i, h2cDout, h2cEmptyN, DW'(i));
      else nPass++;
      tick();
    end
    h2cRead = 0;
    nChecks++; if (h2cEmptyN !== 1'b0) $display("[TB] FAIL drained_empty_n got=%b exp=0", h2cEmptyN); else nPass++;
    nChecks++; if (wFull !== 1'b0) $display("[TB] FAIL drained_full got=%b exp=0", wFull); else nPass++;
  endtask

  task automatic test_h2c_simultaneous();
    int n;
    for (int i = 0; i < 5; i++) begin
      wren = 1; wdata = rndWord(); tick();
    end
    wren = 1; h2cRead = 1; wdata = rndWord(); tick();
    wren = 0;
    n = 0;
    for (int k = 0; k < 20 && h2cEmptyN === 1'b1; k++) begin
      nChecks++; if (h2cDout !== modelHead()) $display("[TB] FAIL simul_data got=%h exp=%h", h2cDout, modelHead()); else nPass++;
      tick();
      n++;
    end
    h2cRead = 0;
    nChecks++; if (n != 5) $display("[TB] FAIL simul_count got=%0d exp=5", n); else nPass++;
    for (int i = 0; i < DEPTH; i++) begin
      wren = 1; wdata = rndWord(); tick();
    end
    wren = 1; h2cRead = 1; wdata = '1; tick();
    wren = 0;
    n = 0;
    for (int k = 0; k < DEPTH + 8 && h2cEmptyN === 1'b1; k++) begin
      nChecks++; if (h2cDout !== modelHead()) $display("[TB] FAIL fullsim_data got=%h exp=%h", h2cDout, modelHead()); else nPass++;
      tick();
      n++;
    end
    h2cRead = 0;
    nChecks++; if (n != DEPTH - 1) $display("[TB] FAIL fullsim_count got=%0d exp=%0d", n, DEPTH - 1); else nPass++;
  endtask

  task automatic test_c2h_eof();
    for (int i = 0; i < 3; i++) begin
      c2hWrite = 1; c2hDin = rndWord(); tick();
      nChecks++; if (rEmpty !== 1'b0) $display("[TB] FAIL c2h_not_empty got=%b exp=0", rEmpty); else nPass++;
    end
    c2hWrite = 0; c2hDone = 1; tick();
    c2hDone = 0;
    nChecks++; if (rEof !== 1'b0) $display("[TB] FAIL eof_early got=%b exp=0", rEof); else nPass++;
    for (int i = 0; i < 3; i++) begin
      rden = 1; tick();
      rden = 0;
      nChecks++; if (rData !== mRd) $display("[TB] FAIL c2h_pop_data got=%h exp=%h", rData, mRd); else nPass++;
      nChecks++; if (rEof !== (i == 2)) $display("[TB] FAIL eof_timing pop=%0d got=%b exp=%b", i, rEof, (i == 2)); else nPass++;
      nChecks++; if (rEmpty !== (i == 2)) $display("[TB] FAIL empty_timing pop=%0d got=%b exp=%b", i, rEmpty, (i == 2)); else nPass++;
    end
    tick();
    nChecks++; if (rData !== mRd) $display("[TB] FAIL rdata_hold got=%h exp=%h", rData, mRd); else nPass++;
    rden = 1; tick(); rden = 0;
    nChecks++; if (rData !== mRd || rEof !== 1'b1) $display("[TB] FAIL pop_when_empty got=%h/%b exp=%h/1", rData, rEof, mRd); else nPass++;
  endtask

  task automatic test_close_flush();
    for (int i = 0; i < 10; i++) begin
      c2hWrite = 1; c2hDin = rndWord(); tick();
    end
    c2hWrite = 0; c2hDone = 1; tick(); c2hDone = 0;
    nChecks++; if (rEmpty !== 1'b0 || rEof !== 1'b0) $display("[TB] FAIL pre_close got=%b/%b exp=0/0", rEmpty, rEof); else nPass++;
    rOpen = 0; tick();
    nChecks++; if (rEmpty !== 1'b1) $display("[TB] FAIL close_empty got=%b exp=1", rEmpty); else nPass++;
    nChecks++; if (rEof !== 1'b0) $display("[TB] FAIL close_eof got=%b exp=0", rEof); else nPass++;
    for (int i = 0; i < 2; i++) begin
      c2hWrite = 1; c2hDin = rndWord(); tick();
    end
    c2hWrite = 0; rOpen = 1; tick();
    rden = 1; tick(); rden = 0;
    nChecks++; if (rData !== mRd || rEmpty !== 1'b0) $display("[TB] FAIL retained got=%h/%b exp=%h/0", rData, rEmpty, mRd); else nPass++;
    rden = 1; tick(); rden = 0;
    rOpen = 0; c2hDone = 1; tick(); c2hDone = 0;
    tick();
    nChecks++; if (rEof !== 1'b0 || rEmpty !== 1'b1) $display("[TB] FAIL done_vs_close got=%b/%b exp=0/1", rEof, rEmpty); else nPass++;
    rOpen = 1; tick();
    for (int i = 0; i < 3; i++) begin
      wren = 1; wdata = rndWord(); tick();
    end
    wren = 0; wOpen = 0; tick();
    nChecks++; if (h2cEmptyN !== 1'b0) $display("[TB] FAIL w_close_flush got=%b exp=0", h2cEmptyN); else nPass++;
    wren = 1; wdata = rndWord(); tick(); tick(); wren = 0;
    nChecks++; if (h2cEmptyN !== 1'b0) $display("[TB] FAIL w_closed_write got=%b exp=0", h2cEmptyN); else nPass++;
    wOpen = 1; tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      wren     = ($urandom_range(0, 9) < 7);
      wdata    = rndWord();
      h2cRead  = ($urandom_range(0, 1) == 1);
      c2hWrite = ($urandom_range(0, 9) < 6);
      c2hDin   = rndWord();
      c2hDone  = ($urandom_range(0, 19) == 0);
      rden     = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 39) == 0) wOpen = ~wOpen;
      if ($urandom_range(0, 39) == 0) rOpen = ~rOpen;
      tick();
      nChecks++;
      if (h2cEmptyN !== (h2cQ.size() > 0) || wFull !== (h2cQ.size() == DEPTH) || h2cOvf !== mOvf)
        $display("[TB] FAIL rnd_h2c_flags cyc=%0d got=%b%b%b exp=%b%b%b", c, h2cEmptyN, wFull, h2cOvf,
                 (h2cQ.size() > 0), (h2cQ.size() == DEPTH), mOvf);
      else nPass++;
      if (h2cQ.size() > 0) begin
        nChecks++; if (h2cDout !== h2cQ[0]) $display("[TB] FAIL rnd_h2c_head cyc=%0d got=%h exp=%h", c, h2cDout, h2cQ[0]); else nPass++;
      end
      nChecks++;
      if (rEmpty !== (c2hQ.size() == 0) || rEof !== (mDone && c2hQ.size() == 0) || c2hFullN !== (c2hQ.size() < DEPTH))
        $display("[TB] FAIL rnd_c2h_flags cyc=%0d got=%b%b%b exp=%b%b%b", c, rEmpty, rEof, c2hFullN,
                 (c2hQ.size() == 0), (mDone && c2hQ.size() == 0), (c2hQ.size() < DEPTH));
      else nPass++;
      nChecks++; if (rData !== mRd) $display("[TB] FAIL rnd_rdata cyc=%0d got=%h exp=%h", c, rData, mRd); else nPass++;
    end
    idleInputs();
    wOpen = 1; rOpen = 1;
    tick();
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < DEPTH / 2; i++) begin
      wren = 1; wdata = rndWord(); c2hWrite = 1; c2hDin = rndWord(); tick();
    end
    idleInputs();
    c2hDone = 1; rden = 1; tick(); idleInputs();
    nChecks++; if (h2cEmptyN !== 1'b1 || rEmpty !== 1'b0) $display("[TB] FAIL half_full got=%b/%b exp=1/0", h2cEmptyN, rEmpty); else nPass++;
    reset = 1; tick();
    nChecks++;
    if (wFull !== 1'b0 || h2cEmptyN !== 1'b0 || rEmpty !== 1'b1 || rEof !== 1'b0 || c2hFullN !== 1'b0 || h2cOvf !== 1'b0 || rData !== '0)
      $display("[TB] FAIL midstream_reset got=%b%b%b%b%b%b rdata=%h exp=001000 rdata=0", wFull, h2cEmptyN, rEmpty, rEof, c2hFullN, h2cOvf, rData);
    else nPass++;
    reset = 0; tick();
    nChecks++; if (c2hFullN !== 1'b1 || h2cEmptyN !== 1'b0 || rEmpty !== 1'b1) $display("[TB] FAIL post_reset got=%b%b%b exp=101", c2hFullN, h2cEmptyN, rEmpty); else nPass++;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog_timeout");
    $fatal(1, "[TB] simulation timed out");
  end

  initial begin
    test_reset();
    test_h2c_fill_drain();
    test_h2c_simultaneous();
    test_c2h_eof();
    test_close_flush();
    test_random();
    test_reset_midstream();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
